// File: rtl/dca_matrix_store_arbiter_pkg.sv
// Shared definitions for the matrix store arbiter: FSM encodings, requester
// count limits and a small modular-add helper used for round-robin indexing.
package dca_matrix_store_arbiter_pkg;

  localparam int NUM_REQ_MIN = 2;
  localparam int NUM_REQ_MAX = 8;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_ISSUE     = 2'd1;
  localparam logic [1:0] ST_SETTLE    = 2'd2;
  localparam logic [1:0] ST_WAIT_DONE = 2'd3;

  // (a + b) mod n for operands already in 0..n-1.
  function automatic int wrap_add(input int a, input int b, input int n);
    return (a + b >= n) ? (a + b - n) : (a + b);
  endfunction

endpackage

// File: rtl/dca_matrix_store_arbiter_if.sv
// Requester and store-engine signals of the matrix store arbiter.
// master = arbiter side, slave = requesters plus store engine.
interface dca_matrix_store_arbiter_if #(
  parameter int NUM_REQ = 2
);
  localparam int IDX_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] req_valid;
  logic [NUM_REQ-1:0] req_accept;
  logic [NUM_REQ-1:0] req_done;
  logic [IDX_W-1:0]   grant_id;
  logic               storereg_wready;
  logic               storereg_wrequest;
  logic               engine_busy;

  modport master (
    input  req_valid, storereg_wready, engine_busy,
    output req_accept, req_done, grant_id, storereg_wrequest
  );

  modport slave (
    output req_valid, storereg_wready, engine_busy,
    input  req_accept, req_done, grant_id, storereg_wrequest
  );

endinterface

// File: rtl/dca_rr_select.sv
// Round-robin priority select: first set request at or above i_ptr, with wrap.
module dca_rr_select
  import dca_matrix_store_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]         i_req,
  input  logic [$clog2(NUM_REQ)-1:0] i_ptr,
  output logic [$clog2(NUM_REQ)-1:0] o_idx,
  output logic                       o_found
);
  localparam int IDX_W = $clog2(NUM_REQ);

  // Scan from the farthest distance down so the nearest hit to i_ptr wins.
  // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    o_idx   = '0;
    o_found = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (i_req[wrap_add(int'(i_ptr), i, NUM_REQ)]) begin
        o_idx   = IDX_W'(wrap_add(int'(i_ptr), i, NUM_REQ));
        o_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dca_matrix_store_arbiter.sv
// Round-robin arbiter granting NUM_REQ store requesters access to one
// mreg-to-store engine, with a wrapping completed-store counter.
module dca_matrix_store_arbiter
  import dca_matrix_store_arbiter_pkg::*;
#(
  parameter int NUM_REQ  = 2,
  parameter int BW_COUNT = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clear,
  input  logic                      enable,
  output logic                      busy,
  dca_matrix_store_arbiter_if.master bus,
  output logic [BW_COUNT-1:0]       store_count
);
  localparam int IDX_W = $clog2(NUM_REQ);

  if (NUM_REQ < NUM_REQ_MIN || NUM_REQ > NUM_REQ_MAX) begin : g_num_req_range
    $error("dca_matrix_store_arbiter: NUM_REQ must be within 2..8");
  end

  logic [1:0]          r_state;
  logic [IDX_W-1:0]    r_grant;
  logic [IDX_W-1:0]    r_rr_ptr;
  logic [BW_COUNT-1:0] r_count;
  logic                r_accept;

  logic [IDX_W-1:0]    w_sel_idx;
  logic                w_found;
  logic                w_done;

  dca_rr_select #(.NUM_REQ(NUM_REQ)) u_rr_select (
    .i_req   (bus.req_valid),
    .i_ptr   (r_rr_ptr),
    .o_idx   (w_sel_idx),
    .o_found (w_found)
  );

  // engine_busy is only looked at in WAIT_DONE; SETTLE covers the cycle where
  // the engine has not yet raised it for the request just handed over.
  assign w_done = (r_state == ST_WAIT_DONE) && !bus.engine_busy &&
                  bus.storereg_wready && enable && !clear;

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_grant  <= '0;
      r_rr_ptr <= '0;
      r_count  <= '0;
      r_accept <= 1'b0;
    end else if (clear) begin
      r_state  <= ST_IDLE;
      r_rr_ptr <= '0;
      r_count  <= '0;
      r_accept <= 1'b0;
    end else if (enable) begin
      r_accept <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_grant  <= w_sel_idx;
            r_accept <= 1'b1;
            r_state  <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (bus.storereg_wready) r_state <= ST_SETTLE;
        end
        ST_SETTLE: r_state <= ST_WAIT_DONE;
        ST_WAIT_DONE: begin
          if (w_done) begin
            r_count  <= r_count + 1'b1;
            r_rr_ptr <= IDX_W'(wrap_add(int'(r_grant), 1, NUM_REQ));
            r_state  <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // The accept flag is held across enable=0 so a frozen grant still pulses once.
  always_comb begin
    bus.req_accept = '0;
    bus.req_done   = '0;
    if (r_accept && enable && !clear) bus.req_accept[r_grant] = 1'b1;
    if (w_done) bus.req_done[r_grant] = 1'b1;
  end

  assign bus.storereg_wrequest = (r_state == ST_ISSUE) && enable;
  assign bus.grant_id          = r_grant;
  assign busy                  = (r_state != ST_IDLE);
  assign store_count           = r_count;

endmodule

// File: tb/tb_dca_matrix_store_arbiter.sv
// Self-checking bench: directed cycle table, multi-cycle corner sequences and
// randomized traffic, all compared against a behavioural model of the arbiter.
module tb_dca_matrix_store_arbiter;
  localparam int N  = 3;
  localparam int BW = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           clear;
  logic           enable;
  logic           busy;
  logic [BW-1:0]  store_count;

  dca_matrix_store_arbiter_if #(.NUM_REQ(N)) bus ();

  dca_matrix_store_arbiter #(.NUM_REQ(N), .BW_COUNT(BW)) dut (
    .clk         (clk),
    .rst         (rst),
    .clear       (clear),
    .enable      (enable),
    .busy        (busy),
    .bus         (bus),
    .store_count (store_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: phase of the current store, its owner, next search start, count.
  localparam int M_FREE = 0, M_ASK = 1, M_SETTLE = 2, M_WAIT = 3;
  int m_stage, m_owner, m_ptr, m_count;
  bit m_pend;

  int o_acc, o_done, o_wreq, o_busy, o_grant, o_cnt;

  typedef struct {
    int rv, wr, eb, en, cl;
    int acc, wreq, done, bsy, grant, cnt;
  } vec_t;
  vec_t tbl[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input int rv, input int wr, input int eb, input int en, input int cl);
    bus.req_valid       = N'(rv);
    bus.storereg_wready = wr[0];
    bus.engine_busy     = eb[0];
    enable              = en[0];
    clear               = cl[0];
  endtask

  task automatic model_reset();
    m_stage = M_FREE;
    m_owner = 0;
    m_ptr   = 0;
    m_count = 0;
    m_pend  = 0;
  endtask

  task automatic model_step();
    int pick;
    if (rst) begin
      model_reset();
    end else if (clear) begin
      m_stage = M_FREE;
      m_ptr   = 0;
      m_count = 0;
      m_pend  = 0;
    end else if (enable) begin
      m_pend = 0;
      case (m_stage)
        M_FREE: begin
          pick = -1;
          for (int d = 0; d < N; d++)
            if (pick < 0 && bus.req_valid[(m_ptr + d) % N]) pick = (m_ptr + d) % N;
          if (pick >= 0) begin
            m_owner = pick;
            m_pend  = 1;
            m_stage = M_ASK;
          end
        end
        M_ASK:    if (bus.storereg_wready) m_stage = M_SETTLE;
        M_SETTLE: m_stage = M_WAIT;
        default: begin
          if (!bus.engine_busy && bus.storereg_wready) begin
            m_count = (m_count + 1) % (1 << BW);
            m_ptr   = (m_owner + 1) % N;
            m_stage = M_FREE;
          end
        end
      endcase
    end
  endtask

  // One clock: sample at the falling edge, compare with the model, then let
  // the model advance on the rising edge. Inputs change at posedge+1.
  task automatic cycle();
    int e_acc, e_done;
    @(negedge clk);
    o_acc   = int'(bus.req_accept);
    o_done  = int'(bus.req_done);
    o_wreq  = int'(bus.storereg_wrequest);
    o_busy  = int'(busy);
    o_grant = int'(bus.grant_id);
    o_cnt   = int'(store_count);
    e_acc  = (m_pend && enable && !clear) ? (1 << m_owner) : 0;
    e_done = (m_stage == M_WAIT && !bus.engine_busy && bus.storereg_wready && enable && !clear)
             ? (1 << m_owner) : 0;
    check("mdl req_accept", o_acc, e_acc);
    check("mdl req_done", o_done, e_done);
    check("mdl wrequest", o_wreq, (m_stage == M_ASK && enable) ? 1 : 0);
    check("mdl busy", o_busy, (m_stage != M_FREE) ? 1 : 0);
    check("mdl grant_id", o_grant, m_owner);
    check("mdl store_count", o_cnt, m_count);
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic run_store(input int rv);
    drive(rv, 1, 0, 1, 0);
    cycle();
    cycle();
    drive(0, 1, 0, 1, 0);
    cycle();
    cycle();
  endtask

  initial begin
    // rv, wr, eb, en, cl | acc, wreq, done, busy, grant, count
    // contention 0,1,0,1 from reset
    tbl.push_back('{'b011, 1, 0, 1, 0,  0,      0, 0,      0, 0, 0});
    tbl.push_back('{'b011, 1, 0, 1, 0,  'b001,  1, 0,      1, 0, 0});
    tbl.push_back('{'b011, 1, 0, 1, 0,  0,      0, 0,      1, 0, 0});
    tbl.push_back('{'b011, 1, 0, 1, 0,  0,      0, 'b001,  1, 0, 0});
    tbl.push_back('{'b011, 1, 0, 1, 0,  0,      0, 0,      0, 0, 1});
    tbl.push_back('{'b011, 1, 0, 1, 0,  'b010,  1, 0,      1, 1, 1});
    tbl.push_back('{'b011, 1, 0, 1, 0,  0,      0, 0,      1, 1, 1});
    tbl.push_back('{'b011, 1, 0, 1, 0,  0,      0, 'b010,  1, 1, 1});
    tbl.push_back('{'b011, 1, 0, 1, 0,  0,      0, 0,      0, 1, 2});
    tbl.push_back('{'b011, 1, 0, 1, 0,  'b001,  1, 0,      1, 0, 2});
    tbl.push_back('{'b011, 1, 0, 1, 0,  0,      0, 0,      1, 0, 2});
    tbl.push_back('{'b011, 1, 0, 1, 0,  0,      0, 'b001,  1, 0, 2});
    tbl.push_back('{'b011, 1, 0, 1, 0,  0,      0, 0,      0, 0, 3});
    tbl.push_back('{'b011, 1, 0, 1, 0,  'b010,  1, 0,      1, 1, 3});
    tbl.push_back('{'b011, 1, 0, 1, 0,  0,      0, 0,      1, 1, 3});
    tbl.push_back('{'b011, 1, 0, 1, 0,  0,      0, 'b010,  1, 1, 3});
    // clear during WAIT_DONE suppresses done, zeroes count and pointer
    tbl.push_back('{'b011, 1, 0, 1, 0,  0,      0, 0,      0, 1, 4});
    tbl.push_back('{'b011, 1, 0, 1, 0,  'b001,  1, 0,      1, 0, 4});
    tbl.push_back('{'b011, 1, 0, 1, 0,  0,      0, 0,      1, 0, 4});
    tbl.push_back('{'b011, 1, 0, 1, 1,  0,      0, 0,      1, 0, 4});
    tbl.push_back('{'b110, 1, 0, 1, 0,  0,      0, 0,      0, 0, 0});
    tbl.push_back('{'b110, 1, 0, 1, 0,  'b010,  1, 0,      1, 1, 0});
    // engine busy; a new request during WAIT_DONE is not granted early
    tbl.push_back('{0,     0, 1, 1, 0,  0,      0, 0,      1, 1, 0});
    tbl.push_back('{'b001, 0, 1, 1, 0,  0,      0, 0,      1, 1, 0});
    tbl.push_back('{'b001, 1, 1, 1, 0,  0,      0, 0,      1, 1, 0});
    tbl.push_back('{'b001, 1, 0, 1, 0,  0,      0, 'b010,  1, 1, 0});
    tbl.push_back('{'b001, 1, 0, 1, 0,  0,      0, 0,      0, 1, 1});
    tbl.push_back('{'b001, 1, 0, 1, 0,  'b001,  1, 0,      1, 0, 1});
    tbl.push_back('{0,     1, 0, 1, 0,  0,      0, 0,      1, 0, 1});
    tbl.push_back('{0,     1, 0, 1, 0,  0,      0, 'b001,  1, 0, 1});
    tbl.push_back('{0,     1, 0, 1, 0,  0,      0, 0,      0, 0, 2});
    // enable low in IDLE and in the first ISSUE cycle
    tbl.push_back('{'b100, 1, 0, 0, 0,  0,      0, 0,      0, 0, 2});
    tbl.push_back('{'b100, 1, 0, 1, 0,  0,      0, 0,      0, 0, 2});
    tbl.push_back('{'b100, 1, 0, 0, 0,  0,      0, 0,      1, 2, 2});
    tbl.push_back('{'b100, 1, 0, 1, 0,  'b100,  1, 0,      1, 2, 2});
    tbl.push_back('{0,     1, 0, 1, 0,  0,      0, 0,      1, 2, 2});
    tbl.push_back('{0,     1, 0, 1, 0,  0,      0, 'b100,  1, 2, 2});
    tbl.push_back('{0,     1, 0, 1, 0,  0,      0, 0,      0, 2, 3});

    rst = 1'b1;
    drive(0, 0, 0, 1, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", int'(busy), 0);
    check("reset wrequest", int'(bus.storereg_wrequest), 0);
    check("reset req_accept", int'(bus.req_accept), 0);
    check("reset req_done", int'(bus.req_done), 0);
    check("reset grant_id", int'(bus.grant_id), 0);
    check("reset store_count", int'(store_count), 0);
    rst = 1'b0;

    foreach (tbl[i]) begin
      drive(tbl[i].rv, tbl[i].wr, tbl[i].eb, tbl[i].en, tbl[i].cl);
      cycle();
      check($sformatf("row%0d req_accept", i), o_acc, tbl[i].acc);
      check($sformatf("row%0d wrequest", i), o_wreq, tbl[i].wreq);
      check($sformatf("row%0d req_done", i), o_done, tbl[i].done);
      check($sformatf("row%0d busy", i), o_busy, tbl[i].bsy);
      check($sformatf("row%0d grant_id", i), o_grant, tbl[i].grant);
      check($sformatf("row%0d store_count", i), o_cnt, tbl[i].cnt);
    end

    // Engine not ready for 5 ISSUE cycles, handshake on the 6th.
    drive('b001, 0, 0, 1, 0);
    cycle();
    for (int k = 0; k < 5; k++) begin
      drive((k == 0) ? 'b001 : 0, 0, 0, 1, 0);
      cycle();
      check($sformatf("stall%0d wrequest", k), o_wreq, 1);
    end
    drive(0, 1, 0, 1, 0);
    cycle();
    check("handshake wrequest", o_wreq, 1);
    cycle();
    check("settle wrequest", o_wreq, 0);
    check("settle busy", o_busy, 1);
    cycle();
    check("stall store done", o_done, 'b001);
    cycle();
    check("stall store count", o_cnt, 4);
    check("stall store idle", o_busy, 0);

    // enable low in WAIT_DONE while the engine finishes.
    drive('b010, 1, 0, 1, 0);
    cycle();
    cycle();
    drive(0, 0, 1, 1, 0);
    cycle();
    cycle();
    check("frozen wait done", o_done, 0);
    for (int k = 0; k < 3; k++) begin
      drive(0, 1, 0, 0, 0);
      cycle();
      check($sformatf("disabled%0d done", k), o_done, 0);
      check($sformatf("disabled%0d busy", k), o_busy, 1);
    end
    drive(0, 1, 0, 1, 0);
    cycle();
    check("deferred done pulse", o_done, 'b010);
    cycle();
    check("deferred done single", o_done, 0);
    check("deferred done idle", o_busy, 0);
    check("deferred done count", o_cnt, 5);

    // Counter wrap: 17 stores on a 4-bit counter.
    drive(0, 1, 0, 1, 1);
    cycle();
    for (int s = 0; s < 17; s++) begin
      run_store('b001);
      if (s == 0) check("wrap first grant", o_grant, 0);
    end
    drive(0, 1, 0, 1, 0);
    cycle();
    check("wrap store_count", o_cnt, 1);

    // Asynchronous reset in the middle of a store, then resume from IDLE.
    drive('b011, 0, 0, 1, 0);
    cycle();
    cycle();
    #2;
    rst = 1'b1;
    #1;
    check("async rst busy", int'(busy), 0);
    check("async rst wrequest", int'(bus.storereg_wrequest), 0);
    check("async rst req_accept", int'(bus.req_accept), 0);
    check("async rst store_count", int'(store_count), 0);
    check("async rst grant_id", int'(bus.grant_id), 0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive('b011, 1, 0, 1, 0);
    cycle();
    check("post rst accept", o_acc, 0);
    check("post rst done", o_done, 0);
    check("post rst wrequest", o_wreq, 0);

    // Random traffic against the model.
    for (int k = 0; k < 400; k++) begin
      drive(int'($urandom_range(0, (1 << N) - 1)),
            ($urandom_range(0, 3) != 0) ? 1 : 0,
            int'($urandom_range(0, 1)),
            ($urandom_range(0, 9) != 0) ? 1 : 0,
            ($urandom_range(0, 29) == 0) ? 1 : 0);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dca_matrix_store_arbiter.md
DCA_MATRIX_STORE_ARBITER -- requirements
Module: dca_matrix_store_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 2 (range 2..8): number of store requesters sharing one mreg-to-store engine.
REQ-002 SHALL have parameter BW_COUNT, default 16: width of the completed-store counter.
REQ-003 SHALL have port clk, input, 1: single clock; all state on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-005 SHALL have port clear, input, 1: synchronous soft reset.
REQ-006 SHALL have port enable, input, 1: when low, state and counters freeze.
REQ-007 SHALL have port busy, output, 1: high whenever the FSM is not IDLE.
REQ-008 SHALL have port req_valid, input, NUM_REQ: per-requester store request, level, held until accepted.
REQ-009 SHALL have port req_accept, output, NUM_REQ: one-cycle pulse to the requester being granted.
REQ-010 SHALL have port req_done, output, NUM_REQ: one-cycle pulse when that requester's store completes.
REQ-011 SHALL have port grant_id, output, clog2(NUM_REQ): index of the current owner; valid while busy.
REQ-012 SHALL have port storereg_wready, input, 1: engine idle and able to take a request.
REQ-013 SHALL have port storereg_wrequest, output, 1: store start request to the engine.
REQ-014 SHALL have port engine_busy, input, 1: engine busy flag.
REQ-015 SHALL have port store_count, output, BW_COUNT: number of completed stores.

Function
REQ-016 SHALL implement FSM states IDLE, ISSUE, SETTLE and WAIT_DONE; state advances only when enable=1.
REQ-017 IDLE: if any req_valid bit is set, SHALL select the first set bit scanning upward from rr_ptr with wrap, latch it into grant_id, pulse req_accept[grant_id], and go to ISSUE.
REQ-018 ISSUE: SHALL drive storereg_wrequest=1; on storereg_wready=1 in the same cycle (handshake), SHALL go to SETTLE.
REQ-019 SETTLE: SHALL last exactly one cycle, masking engine_busy while the engine registers the request; then go to WAIT_DONE.
REQ-020 WAIT_DONE: when engine_busy=0 and storereg_wready=1, SHALL pulse req_done[grant_id], increment store_count, set rr_ptr=(grant_id+1) mod NUM_REQ, and go to IDLE.
REQ-021 storereg_wrequest SHALL be the combinational value (state==ISSUE) & enable.
REQ-022 Grant-to-wrequest latency SHALL be 1 cycle; minimum request-to-request turnaround SHALL be 4 cycles.
REQ-023 Deasserting req_valid after acceptance SHALL NOT abort the granted store.
REQ-024 A requester whose bit is set during WAIT_DONE SHALL NOT be granted until the FSM has returned to IDLE.
REQ-025 store_count SHALL wrap modulo 2^BW_COUNT.
REQ-026 clear SHALL have priority over enable, return the FSM to IDLE, zero rr_ptr and store_count, and suppress req_done; an engine store in flight is not aborted by this block.
REQ-027 With enable=0, all pulse outputs SHALL be 0 and storereg_wrequest SHALL be 0.

Reset
REQ-028 On rst=1, SHALL asynchronously set state IDLE, rr_ptr 0, grant_id 0, store_count 0, and drive busy, req_accept, req_done and storereg_wrequest to 0.
REQ-029 Reset deassertion mid-operation SHALL resume from IDLE, with no pulses in the first cycle.

Structure
REQ-030 FSM state encodings and the NUM_REQ range limit SHALL reside in a shared dca package or include file.
REQ-031 A round-robin priority-select sub-module, dca_rr_select (inputs request vector and pointer; outputs index and found), SHALL be instantiated.

Verification
REQ-032 Single request: req_valid=01 with the engine idle -> req_accept[0] at cycle 1, wrequest at cycle 1, req_done[0] after engine_busy falls, store_count=1.
REQ-033 Contention: req_valid=11 held -> grant order 0,1,0,1 over four stores; store_count=4.
REQ-034 Engine not ready: storereg_wready=0 for 5 cycles in ISSUE -> wrequest held for 5 cycles; handshake on the 6th cycle.
REQ-035 clear asserted during WAIT_DONE -> IDLE next cycle, no req_done, store_count=0, rr_ptr=0.
REQ-036 enable=0 for 3 cycles in WAIT_DONE while the engine finishes -> done is deferred until enable=1, then a single req_done pulse.
REQ-037 Counter wrap with BW_COUNT=4: 17 stores -> store_count=1.
